// File: rtl/id_issue_buf_pkg.sv
// Shared constants for the decode-stage issue buffer: stall-bus bit positions,
// slot-state encoding and the hard-wired zero register index.
package id_issue_buf_pkg;

  localparam int unsigned STALL_IF_ID = 1;
  localparam int unsigned STALL_ID_EX = 2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'b00,
    SLOT_LIVE  = 2'b01,
    SLOT_HELD  = 2'b10
  } slot_state_e;

endpackage

// File: rtl/id_fwd_mux.sv
// Single-operand forwarding mux: lowest-index matching source wins, register
// zero always reads as zero, and the winner's data-not-ready flag is reported.
module id_fwd_mux
  import id_issue_buf_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3
) (
  input  logic [4:0]              raddr_i,
  input  logic [NUM_FWD-1:0]      fwd_we_i,
  input  logic [NUM_FWD-1:0]      fwd_is_load_i,
  input  logic [NUM_FWD*5-1:0]    fwd_waddr_i,
  input  logic [NUM_FWD*XLEN-1:0] fwd_wdata_i,
  input  logic [XLEN-1:0]         rf_rdata_i,
  output logic [XLEN-1:0]         data_o,
  output logic                    load_o
);

  logic hit_s;

  // Priority scan; once a source has matched, later ones are ignored.
  always_comb begin
    hit_s  = 1'b0;
    data_o = rf_rdata_i;
    load_o = 1'b0;
    if (raddr_i == REG_ZERO) begin
      data_o = '0;
    end else begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!hit_s && fwd_we_i[i] && (fwd_waddr_i[i*5 +: 5] == raddr_i)) begin
          hit_s  = 1'b1;
          data_o = fwd_wdata_i[i*XLEN +: XLEN];
          load_o = fwd_is_load_i[i];
        end else begin
          hit_s  = hit_s;
        end
      end
    end
  end

endmodule

// File: rtl/id_issue_buf.sv
// IF/ID issue slot: registers the fetched PC, holds the SRAM word across
// back-pressure, forwards operands and raises the load-use interlock.
module id_issue_buf
  import id_issue_buf_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic                    if_valid,
  input  logic [31:0]             if_pc,
  input  logic [XLEN-1:0]         inst_rdata,
  input  logic [NUM_FWD-1:0]      fwd_we,
  input  logic [NUM_FWD-1:0]      fwd_is_load,
  input  logic [NUM_FWD*5-1:0]    fwd_waddr,
  input  logic [NUM_FWD*XLEN-1:0] fwd_wdata,
  output logic [4:0]              rf_raddr1,
  output logic [4:0]              rf_raddr2,
  input  logic [XLEN-1:0]         rf_rdata1,
  input  logic [XLEN-1:0]         rf_rdata2,
  output logic                    id_valid,
  output logic [31:0]             id_pc,
  output logic [XLEN-1:0]         id_inst,
  output logic [XLEN-1:0]         src1_data,
  output logic [XLEN-1:0]         src2_data,
  output logic                    stallreq,
  output logic [CNT_W-1:0]        perf_interlock_cnt
);

  slot_state_e      state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [XLEN-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load1_s, load2_s;
  logic             unused_stall_s;

  assign unused_stall_s = ^stall;

  // Slot state, PC, hold word and interlock counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SLOT_EMPTY;
      pc_q    <= 32'd0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: IF/ID advance, bubble insertion, or freeze with the SRAM word
  // latched on the first held cycle since the SRAM output will move on.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    if (!stall[STALL_IF_ID]) begin
      state_d = if_valid ? SLOT_LIVE : SLOT_EMPTY;
      pc_d    = if_pc;
    end else if (!stall[STALL_ID_EX]) begin
      state_d = SLOT_EMPTY;
      pc_d    = 32'd0;
    end else begin
      case (state_q)
        SLOT_LIVE: begin
          state_d = SLOT_HELD;
          hold_d  = inst_rdata;
        end
        SLOT_HELD:  state_d = SLOT_HELD;
        SLOT_EMPTY: state_d = SLOT_EMPTY;
        default:    state_d = SLOT_EMPTY;
      endcase
    end
  end

  // Instruction word presented to decode.
  always_comb begin
    id_inst = '0;
    case (state_q)
      SLOT_LIVE: id_inst = inst_rdata;
      SLOT_HELD: id_inst = hold_q;
      default:   id_inst = '0;
    endcase
  end

  assign id_valid  = (state_q != SLOT_EMPTY);
  assign id_pc     = pc_q;
  assign rf_raddr1 = id_inst[25:21];
  assign rf_raddr2 = id_inst[20:16];

  id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs (
    .raddr_i       (rf_raddr1),
    .fwd_we_i      (fwd_we),
    .fwd_is_load_i (fwd_is_load),
    .fwd_waddr_i   (fwd_waddr),
    .fwd_wdata_i   (fwd_wdata),
    .rf_rdata_i    (rf_rdata1),
    .data_o        (src1_data),
    .load_o        (load1_s)
  );

  id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rt (
    .raddr_i       (rf_raddr2),
    .fwd_we_i      (fwd_we),
    .fwd_is_load_i (fwd_is_load),
    .fwd_waddr_i   (fwd_waddr),
    .fwd_wdata_i   (fwd_wdata),
    .rf_rdata_i    (rf_rdata2),
    .data_o        (src2_data),
    .load_o        (load2_s)
  );

  assign stallreq = id_valid && (load1_s || load2_s);

  // Saturating interlock counter.
  always_comb begin
    cnt_d = cnt_q;
    if (stallreq && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign perf_interlock_cnt = cnt_q;

endmodule

// File: tb/tb_id_issue_buf.sv
// Directed plus random bench for id_issue_buf against a slot/forwarding model;
// a narrow counter width makes saturation reachable quickly.
module tb_id_issue_buf;

  localparam int XLEN    = 32;
  localparam int NUM_FWD = 3;
  localparam int STALL_W = 6;
  localparam int CNT_W   = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [STALL_W-1:0]      stall = '0;
  logic                    if_valid = 1'b0;
  logic [31:0]             if_pc = '0;
  logic [XLEN-1:0]         inst_rdata = '0;
  logic [NUM_FWD-1:0]      fwd_we = '0;
  logic [NUM_FWD-1:0]      fwd_is_load = '0;
  logic [NUM_FWD*5-1:0]    fwd_waddr = '0;
  logic [NUM_FWD*XLEN-1:0] fwd_wdata = '0;
  logic [XLEN-1:0]         rf_rdata1 = '0;
  logic [XLEN-1:0]         rf_rdata2 = '0;
  logic [4:0]              rf_raddr1, rf_raddr2;
  logic                    id_valid, stallreq;
  logic [31:0]             id_pc;
  logic [XLEN-1:0]         id_inst, src1_data, src2_data;
  logic [CNT_W-1:0]        perf_interlock_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: slot occupancy, whether the word comes from the hold copy, PC, counter.
  bit          m_valid, m_held;
  logic [31:0] m_pc, m_hold;
  int          m_cnt;

  always #5 clk = ~clk;

  id_issue_buf #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .STALL_W(STALL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
    .inst_rdata(inst_rdata), .fwd_we(fwd_we), .fwd_is_load(fwd_is_load),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .rf_raddr1(rf_raddr1),
    .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .src1_data(src1_data),
    .src2_data(src2_data), .stallreq(stallreq), .perf_interlock_cnt(perf_interlock_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Later (higher index) sources are overwritten by earlier ones: lowest index wins.
  function automatic void pick(input logic [4:0] a, input logic [31:0] rf,
                               output logic [31:0] d, output bit ld);
    d  = rf;
    ld = 1'b0;
    for (int i = NUM_FWD-1; i >= 0; i--) begin
      if (fwd_we[i] && fwd_waddr[i*5 +: 5] == a) begin
        d  = fwd_wdata[i*XLEN +: XLEN];
        ld = fwd_is_load[i];
      end
    end
    if (a == 5'd0) begin
      d  = 32'd0;
      ld = 1'b0;
    end
  endfunction

  function automatic logic [31:0] exp_inst();
    if (!m_valid) return 32'd0;
    return m_held ? m_hold : inst_rdata;
  endfunction

  function automatic bit exp_stall();
    logic [31:0] d1, d2;
    bit l1, l2;
    logic [31:0] w;
    w = exp_inst();
    pick(w[25:21], rf_rdata1, d1, l1);
    pick(w[20:16], rf_rdata2, d2, l2);
    return m_valid && (l1 || l2);
  endfunction

  task automatic m_reset();
    m_valid = 1'b0; m_held = 1'b0; m_pc = 32'd0; m_hold = 32'd0; m_cnt = 0;
  endtask

  task automatic check_all();
    logic [31:0] w, d1, d2;
    bit l1, l2;
    w = exp_inst();
    pick(w[25:21], rf_rdata1, d1, l1);
    pick(w[20:16], rf_rdata2, d2, l2);
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
    chk("id_pc", id_pc, m_pc);
    chk("id_inst", id_inst, w);
    chk("rf_raddr1", {27'd0, rf_raddr1}, {27'd0, w[25:21]});
    chk("rf_raddr2", {27'd0, rf_raddr2}, {27'd0, w[20:16]});
    chk("src1_data", src1_data, d1);
    chk("src2_data", src2_data, d2);
    chk("stallreq", {31'd0, stallreq}, {31'd0, exp_stall()});
    chk("perf_cnt", {28'd0, perf_interlock_cnt}, m_cnt);
  endtask

  task automatic advance();
    if (!rst) begin
      m_reset();
    end else begin
      if (exp_stall() && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (!stall[1]) begin
        m_valid = if_valid; m_held = 1'b0; m_pc = if_pc;
      end else if (!stall[2]) begin
        m_valid = 1'b0; m_held = 1'b0; m_pc = 32'd0;
      end else if (m_valid && !m_held) begin
        m_held = 1'b1; m_hold = inst_rdata;
      end
    end
  endtask

  task automatic tick();
    #2;
    check_all();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int i, input bit we, input bit ld, input logic [4:0] a,
                         input logic [31:0] d);
    fwd_we[i] = we;
    fwd_is_load[i] = ld;
    fwd_waddr[i*5 +: 5] = a;
    fwd_wdata[i*XLEN +: XLEN] = d;
  endtask

  initial begin
    int c0;
    logic [31:0] w;
    m_reset();
    rf_rdata1 = 32'hA5A5_0001;
    rf_rdata2 = 32'h5A5A_0002;
    #1 rst = 1'b0;
    #1 check_all();
    @(posedge clk); #1;
    check_all();
    rst = 1'b1;

    // Fetch at the reset vector, word appears one cycle later.
    if_pc = 32'hBFC0_0000; if_valid = 1'b1; stall = 6'b000000; inst_rdata = 32'h1357_9BDF;
    tick();
    inst_rdata = 32'h3C01_1234;
    #1;
    chk("fetch_inst", id_inst, 32'h3C01_1234);
    chk("fetch_raddr2", {27'd0, rf_raddr2}, 32'd1);
    chk("fetch_pc", id_pc, 32'hBFC0_0000);

    // Freeze IF/ID and ID/EX: the word must survive SRAM data changing.
    stall = 6'b000110;
    tick();
    inst_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      #1 chk("held_inst", id_inst, 32'h3C01_1234);
      tick();
    end
    stall = 6'b000000; if_pc = 32'hBFC0_0004;
    tick();
    #1 chk("release_live", id_inst, 32'hDEAD_BEEF);

    // Forward priority on rs and the zero register.
    inst_rdata = {6'd0, 5'd5, 5'd9, 16'd0};
    set_fwd(0, 1'b1, 1'b0, 5'd5, 32'h11);
    set_fwd(1, 1'b1, 1'b0, 5'd5, 32'h22);
    #1 chk("fwd_ex_wins", src1_data, 32'h11);
    tick();
    inst_rdata = {6'd0, 5'd0, 5'd9, 16'd0};
    set_fwd(0, 1'b1, 1'b0, 5'd0, 32'h33);
    #1 chk("fwd_r0", src1_data, 32'd0);
    tick();

    // Load-use on rt from EX, counter steps once per interlocked cycle.
    set_fwd(1, 1'b0, 1'b0, 5'd0, 32'd0);
    inst_rdata = {6'd0, 5'd3, 5'd8, 16'd0};
    set_fwd(0, 1'b1, 1'b1, 5'd8, 32'h44);
    c0 = m_cnt;
    #1 chk("loaduse_req", {31'd0, stallreq}, 32'd1);
    for (int k = 0; k < 3; k++) tick();
    chk("loaduse_cnt", {28'd0, perf_interlock_cnt}, c0 + 3);
    set_fwd(0, 1'b1, 1'b0, 5'd8, 32'h55);
    set_fwd(1, 1'b1, 1'b1, 5'd8, 32'h66);
    #1 chk("shadowed_load", {31'd0, stallreq}, 32'd0);
    tick();

    // Saturation.
    set_fwd(0, 1'b1, 1'b1, 5'd8, 32'h77);
    for (int k = 0; k < 20; k++) tick();
    chk("cnt_saturate", {28'd0, perf_interlock_cnt}, 32'hF);

    // Asynchronous reset while holding.
    stall = 6'b000110;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_inst", id_inst, 32'd0);
    chk("rst_cnt", {28'd0, perf_interlock_cnt}, 32'd0);
    m_reset();
    tick();
    rst = 1'b1;
    tick();
    stall = 6'b000000; if_valid = 1'b1; if_pc = 32'h0000_1000;
    tick();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      stall = STALL_W'($urandom);
      if (($urandom & 32'h3) != 0) stall[1] = 1'b0;
      if_valid = 1'($urandom);
      if_pc = $urandom;
      w = $urandom;
      w[25:21] = 5'($urandom_range(0, 7));
      w[20:16] = 5'($urandom_range(0, 7));
      inst_rdata = w;
      for (int i = 0; i < NUM_FWD; i++)
        set_fwd(i, 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
